// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS core: FSM states, opcode and
// funct encodings, the 3-bit ALU control code and the ALU helper function.
package mips_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXEC, S_ALUWB, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP, S_TRAP
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // Same code points as the single-cycle ALU; shifts use the spare codes.
  typedef enum logic [2:0] {
    ALU_AND = 3'b000, ALU_OR  = 3'b001, ALU_ADD = 3'b010, ALU_SLL = 3'b011,
    ALU_SRL = 3'b100, ALU_SUB = 3'b110, ALU_SLT = 3'b111
  } alu_ctrl_e;

  typedef enum logic [1:0] {PC_HOLD, PC_PLUS4, PC_BTA, PC_JUMP} pc_src_e;
  typedef enum logic [1:0] {AO_HOLD, AO_BTA, AO_ALU} ao_src_e;
  typedef enum logic [1:0] {SB_REG, SB_SEXT, SB_ZEXT} srcb_e;

  // Per-cycle control word; all-zero means "do nothing".
  typedef struct packed {
    logic      mem_req;
    logic      mem_we;
    logic      addr_alu;     // 1: address from ALUOut, 0: from PC
    logic      ir_we;
    logic      mdr_we;
    logic      ab_we;
    pc_src_e   pc_src;
    ao_src_e   ao_src;
    alu_ctrl_e alu_ctrl;
    srcb_e     srcb;
    logic      rf_we;
    logic      rf_dst_rd;    // 1: write rd, 0: write rt
    logic      rf_from_mdr;  // 1: write MDR, 0: write ALUOut
    logic      retire;
    logic      trap;
  } ctrl_t;

  function automatic logic [31:0] alu_op(input alu_ctrl_e ctl, input logic [31:0] a,
                                         input logic [31:0] b, input logic [4:0] shamt);
    logic [31:0] r;
    case (ctl)
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_ADD: r = a + b;
      ALU_SUB: r = a - b;
      ALU_SLT: r = {31'b0, ($signed(a) < $signed(b))};
      ALU_SLL: r = b << shamt;
      ALU_SRL: r = b >> shamt;
      default: r = a + b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mips_mc_fsm.sv
// Multi-cycle MIPS control FSM: state register, next-state logic and the
// per-state control word. Optional extended ALU ops (bne, andi, ori, slti,
// sll, srl) are enabled by defining MIPS_EXT_ALU_EN.
module mips_mc_fsm
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  input  logic       a_eq_b,
  output ctrl_t      ctrl
);

  state_e state_q, state_d;
  logic   branch_take;

`ifdef MIPS_EXT_ALU_EN
  assign branch_take = (opcode == OP_BNE) ? !a_eq_b : a_eq_b;
`else
  assign branch_take = a_eq_b;
`endif

  // State register; reset parks the core in IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state and control word for the current state.
  always_comb begin
    state_d = state_q;
    ctrl    = '0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        ctrl.mem_req = 1'b1;
        if (mem_ready) begin
          ctrl.ir_we  = 1'b1;
          ctrl.pc_src = PC_PLUS4;
          state_d     = S_DECODE;
        end
      end
      S_DECODE: begin
        ctrl.ab_we  = 1'b1;
        ctrl.ao_src = AO_BTA;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
`ifdef MIPS_EXT_ALU_EN
          OP_BNE:                   state_d = S_BRANCH;
          OP_ANDI, OP_ORI, OP_SLTI: state_d = S_ADDIEX;
`endif
          default:      state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        ctrl.ao_src   = AO_ALU;
        ctrl.alu_ctrl = ALU_ADD;
        ctrl.srcb     = SB_SEXT;
        state_d       = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        ctrl.mem_req  = 1'b1;
        ctrl.addr_alu = 1'b1;
        if (mem_ready) begin
          ctrl.mdr_we = 1'b1;
          state_d     = S_MEMWB;
        end
      end
      S_MEMWB: begin
        ctrl.rf_we       = 1'b1;
        ctrl.rf_from_mdr = 1'b1;
        ctrl.retire      = 1'b1;
        state_d          = S_FETCH;
      end
      S_MEMWR: begin
        ctrl.mem_req  = 1'b1;
        ctrl.mem_we   = 1'b1;
        ctrl.addr_alu = 1'b1;
        if (mem_ready) begin
          ctrl.retire = 1'b1;
          state_d     = S_FETCH;
        end
      end
      S_EXEC: begin
        ctrl.ao_src = AO_ALU;
        state_d     = S_ALUWB;
        case (funct)
          FN_ADD: ctrl.alu_ctrl = ALU_ADD;
          FN_SUB: ctrl.alu_ctrl = ALU_SUB;
          FN_AND: ctrl.alu_ctrl = ALU_AND;
          FN_OR:  ctrl.alu_ctrl = ALU_OR;
          FN_SLT: ctrl.alu_ctrl = ALU_SLT;
`ifdef MIPS_EXT_ALU_EN
          FN_SLL: ctrl.alu_ctrl = ALU_SLL;
          FN_SRL: ctrl.alu_ctrl = ALU_SRL;
`endif
          default: begin
            // Illegal funct: leave ALUOut untouched and stop.
            ctrl.ao_src = AO_HOLD;
            state_d     = S_TRAP;
          end
        endcase
      end
      S_ALUWB: begin
        ctrl.rf_we     = 1'b1;
        ctrl.rf_dst_rd = 1'b1;
        ctrl.retire    = 1'b1;
        state_d        = S_FETCH;
      end
      S_BRANCH: begin
        // ALUOut still holds the target computed in DECODE.
        if (branch_take) ctrl.pc_src = PC_BTA;
        ctrl.retire = 1'b1;
        state_d     = S_FETCH;
      end
      S_ADDIEX: begin
        ctrl.ao_src   = AO_ALU;
        ctrl.alu_ctrl = ALU_ADD;
        ctrl.srcb     = SB_SEXT;
        state_d       = S_ADDIWB;
`ifdef MIPS_EXT_ALU_EN
        // IR is stable from DECODE on, so the opcode selects the I-type op.
        case (opcode)
          OP_ANDI: begin ctrl.alu_ctrl = ALU_AND; ctrl.srcb = SB_ZEXT; end
          OP_ORI:  begin ctrl.alu_ctrl = ALU_OR;  ctrl.srcb = SB_ZEXT; end
          OP_SLTI: ctrl.alu_ctrl = ALU_SLT;
          default: ;
        endcase
`endif
      end
      S_ADDIWB: begin
        ctrl.rf_we  = 1'b1;
        ctrl.retire = 1'b1;
        state_d     = S_FETCH;
      end
      S_JUMP: begin
        ctrl.pc_src = PC_JUMP;
        ctrl.retire = 1'b1;
        state_d     = S_FETCH;
      end
      S_TRAP:  ctrl.trap = 1'b1;
      default: state_d = S_TRAP;
    endcase
  end

endmodule

// File: rtl/mips_multicycle.sv
// Multi-cycle MIPS core top: datapath registers (PC, IR, MDR, A, B, ALUOut),
// register file and the shared memory port. Control comes from mips_mc_fsm;
// the optional MIPS_EXT_ALU_EN instruction set lives entirely in the FSM.
// ADDR_W is expected to be at most 32.
module mips_multicycle
  import mips_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int                REG_COUNT = 32
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] pc,
  output logic              retire,
  output logic              trap
);

  localparam int                RW        = $clog2(REG_COUNT);
  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

  ctrl_t             ctrl;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       ir_q, ir_d, mdr_q, mdr_d, a_q, a_d, b_q, b_d, aluout_q, aluout_d;
  logic [31:0]       regs_q [REG_COUNT];

  logic [31:0]       sext_imm, zext_imm, alu_b, alu_res, pc32, bta, jt;
  logic [RW-1:0]     rs_idx, rt_idx, rd_idx, rf_waddr;
  logic [31:0]       rf_wdata;
  logic [ADDR_W-1:0] addr_mux;

  assign sext_imm = {{16{ir_q[15]}}, ir_q[15:0]};
  assign zext_imm = {16'h0, ir_q[15:0]};
  assign rs_idx   = ir_q[21 +: RW];
  assign rt_idx   = ir_q[16 +: RW];
  assign rd_idx   = ir_q[11 +: RW];
  assign pc32     = 32'(pc_q);
  assign bta      = pc32 + {sext_imm[29:0], 2'b00};
  assign jt       = {pc32[31:28], ir_q[25:0], 2'b00};
  assign rf_waddr = ctrl.rf_dst_rd ? rd_idx : rt_idx;
  assign rf_wdata = ctrl.rf_from_mdr ? mdr_q : aluout_q;

  mips_mc_fsm u_fsm (
    .clk       (clk),
    .rst       (rst),
    .opcode    (ir_q[31:26]),
    .funct     (ir_q[5:0]),
    .mem_ready (mem_ready),
    .a_eq_b    (a_q == b_q),
    .ctrl      (ctrl)
  );

  // ALU second operand and result.
  always_comb begin
    alu_b = b_q;
    case (ctrl.srcb)
      SB_SEXT: alu_b = sext_imm;
      SB_ZEXT: alu_b = zext_imm;
      default: alu_b = b_q;
    endcase
    alu_res = alu_op(ctrl.alu_ctrl, a_q, alu_b, ir_q[10:6]);
  end

  // Next values of the datapath registers, gated by the control enables.
  always_comb begin
    pc_d = pc_q;
    case (ctrl.pc_src)
      PC_PLUS4: pc_d = pc_q + ADDR_W'(4);
      PC_BTA:   pc_d = aluout_q[ADDR_W-1:0];
      PC_JUMP:  pc_d = jt[ADDR_W-1:0];
      default:  pc_d = pc_q;
    endcase
    ir_d     = ctrl.ir_we  ? mem_rdata       : ir_q;
    mdr_d    = ctrl.mdr_we ? mem_rdata       : mdr_q;
    a_d      = ctrl.ab_we  ? regs_q[rs_idx]  : a_q;
    b_d      = ctrl.ab_we  ? regs_q[rt_idx]  : b_q;
    aluout_d = aluout_q;
    case (ctrl.ao_src)
      AO_BTA:  aluout_d = bta;
      AO_ALU:  aluout_d = alu_res;
      default: aluout_d = aluout_q;
    endcase
  end

  // Datapath register bank.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      mdr_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      aluout_q <= '0;
    end else begin
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      mdr_q    <= mdr_d;
      a_q      <= a_d;
      b_q      <= b_d;
      aluout_q <= aluout_d;
    end
  end

  // Register file; entry 0 is never written so it always reads zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
    end else if (ctrl.rf_we && (rf_waddr != '0)) begin
      regs_q[rf_waddr] <= rf_wdata;
    end
  end

  assign addr_mux  = ctrl.addr_alu ? aluout_q[ADDR_W-1:0] : pc_q;
  assign mem_addr  = addr_mux & WORD_MASK;
  assign mem_req   = ctrl.mem_req;
  assign mem_we    = ctrl.mem_we;
  assign mem_wdata = b_q;
  assign pc        = pc_q;
  assign retire    = ctrl.retire;
  assign trap      = ctrl.trap;

endmodule
